// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC decimator.
package cic_pkg;

  localparam int DEFAULT_STAGES        = 3;
  localparam int DEFAULT_MAX_DECIM_LOG2 = 6;

  // Internal width: enough headroom for R^N gain at the largest ratio.
  function automatic int cic_width(input int sample_size, input int stages,
                                   input int max_decim_log2);
    return sample_size + stages * max_decim_log2;
  endfunction

endpackage

// File: rtl/cic_comb_chain.sv
// Comb section of the CIC decimator: N comb delay registers (M = 1) and the
// output scaling path (arithmetic shift by STAGES*ratio_log2).
// Optional macro CIC_ROUND_EN: round half up before the shift and saturate
// the rounding carry; without it the shift truncates toward minus infinity.
module cic_comb_chain
  import cic_pkg::*;
#(
  parameter int SAMPLE_SIZE    = 16,
  parameter int STAGES         = DEFAULT_STAGES,
  parameter int MAX_DECIM_LOG2 = DEFAULT_MAX_DECIM_LOG2,
  localparam int W  = cic_width(SAMPLE_SIZE, STAGES, MAX_DECIM_LOG2),
  localparam int SW = $clog2(STAGES * MAX_DECIM_LOG2 + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [2:0]                    ratio_log2,
  input  logic signed [W-1:0]           c_in,
  output logic signed [SAMPLE_SIZE-1:0] y
);

  logic signed [W-1:0] d     [STAGES];
  logic signed [W-1:0] c_tap [STAGES];
  logic signed [W-1:0] c_out;
  logic [SW-1:0]       shift_amt;

  // Comb cascade: each stage subtracts its delayed input; c_tap[k] feeds d[k].
  always_comb begin
    logic signed [W-1:0] acc;
    acc = c_in;
    for (int k = 0; k < STAGES; k++) begin
      c_tap[k] = acc;
      acc      = acc - d[k];
    end
    c_out     = acc;
    shift_amt = SW'(STAGES * int'(ratio_log2));
  end

  // Delay registers advance only when a frame completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) d[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) d[k] <= c_tap[k];
    end
  end

`ifdef CIC_ROUND_EN
  localparam logic signed [W:0] SAT_MAX = (W+1)'((2 ** (SAMPLE_SIZE - 1)) - 1);
  localparam logic signed [W:0] SAT_MIN = ~SAT_MAX;

  logic signed [W:0] rnd_sum;
  logic signed [W:0] rnd_shift;

  // Round half up, shift, then clamp the one-LSB carry the rounding can add.
  always_comb begin
    rnd_sum = {c_out[W-1], c_out};
    if (shift_amt != '0) rnd_sum = rnd_sum + ((W+1)'(1) << (shift_amt - SW'(1)));
    rnd_shift = rnd_sum >>> shift_amt;
    if (rnd_shift > SAT_MAX)      y = SAT_MAX[SAMPLE_SIZE-1:0];
    else if (rnd_shift < SAT_MIN) y = SAT_MIN[SAMPLE_SIZE-1:0];
    else                          y = rnd_shift[SAMPLE_SIZE-1:0];
  end
`else
  logic signed [W-1:0] trunc_shift;

  // Plain arithmetic shift; the scaled result always fits the sample width.
  always_comb begin
    trunc_shift = c_out >>> shift_amt;
    y           = trunc_shift[SAMPLE_SIZE-1:0];
  end
`endif

endmodule

// File: rtl/cic_decimator.sv
// Streaming CIC decimator: N integrators at the input rate, N combs at the
// output rate, decimation by 2^decim_log2 with unity DC gain.
// Optional macro CIC_ROUND_EN selects round-half-up output scaling.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int SAMPLE_SIZE    = 16,
  parameter int STAGES         = DEFAULT_STAGES,
  parameter int MAX_DECIM_LOG2 = DEFAULT_MAX_DECIM_LOG2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    decim_log2,
  input  logic                          s_tvalid,
  input  logic signed [SAMPLE_SIZE-1:0] s_tdata,
  output logic                          s_tready,
  output logic                          m_tvalid,
  output logic signed [SAMPLE_SIZE-1:0] m_tdata,
  input  logic                          m_tready
);

  localparam int W  = cic_width(SAMPLE_SIZE, STAGES, MAX_DECIM_LOG2);
  localparam int PW = (MAX_DECIM_LOG2 > 0) ? MAX_DECIM_LOG2 : 1;

  logic signed [W-1:0]           integ     [STAGES];
  logic signed [W-1:0]           integ_nxt [STAGES];
  logic [PW-1:0]                 phase;
  logic [PW-1:0]                 phase_last;
  logic [2:0]                    ratio_q;
  logic [2:0]                    ratio_in;
  logic [2:0]                    ratio_eff;
  logic                          s_accept;
  logic                          frame_done;
  logic signed [SAMPLE_SIZE-1:0] comb_y;

  assign s_tready = !m_tvalid | m_tready;
  assign s_accept = s_tvalid & s_tready;

  // Ratio in force for this accept: a new frame takes the (clamped) input,
  // later phases keep the value latched at frame start.
  always_comb begin
    ratio_in   = (decim_log2 > 3'(MAX_DECIM_LOG2)) ? 3'(MAX_DECIM_LOG2) : decim_log2;
    ratio_eff  = (phase == '0) ? ratio_in : ratio_q;
    phase_last = ~({PW{1'b1}} << ratio_eff);
    frame_done = s_accept & (phase == phase_last);
  end

  // Integrator cascade as one combinational adder chain per accept.
  always_comb begin
    logic signed [W-1:0] acc;
    acc = {{(W-SAMPLE_SIZE){s_tdata[SAMPLE_SIZE-1]}}, s_tdata};
    for (int k = 0; k < STAGES; k++) begin
      acc          = integ[k] + acc;
      integ_nxt[k] = acc;
    end
  end

  // Integrator state, phase counter and frame ratio latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) integ[k] <= '0;
      phase   <= '0;
      ratio_q <= '0;
    end else if (s_accept) begin
      for (int k = 0; k < STAGES; k++) integ[k] <= integ_nxt[k];
      phase <= frame_done ? '0 : phase + PW'(1);
      if (phase == '0) ratio_q <= ratio_in;
    end
  end

  cic_comb_chain #(
    .SAMPLE_SIZE    (SAMPLE_SIZE),
    .STAGES         (STAGES),
    .MAX_DECIM_LOG2 (MAX_DECIM_LOG2)
  ) u_comb (
    .clk        (clk),
    .reset      (reset),
    .en         (frame_done),
    .ratio_log2 (ratio_eff),
    .c_in       (integ_nxt[STAGES-1]),
    .y          (comb_y)
  );

  // Single-entry output register; a completing frame wins over a drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
    end else if (frame_done) begin
      m_tvalid <= 1'b1;
      m_tdata  <= comb_y;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Directed self-checking bench for cic_decimator (defaults N=3, MAX=6).
module tb_cic_decimator;

  localparam int S = 16;

`ifdef CIC_ROUND_EN
  localparam int DC0 = 313;
  localparam int DC1 = 938;
  localparam int IMP40_1 = 4;
`else
  localparam int DC0 = 312;
  localparam int DC1 = 937;
  localparam int IMP40_1 = 3;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [2:0]           decim_log2 = 3'd0;
  logic                 s_tvalid = 1'b0;
  logic signed [S-1:0]  s_tdata = '0;
  logic                 s_tready;
  logic                 m_tvalid;
  logic signed [S-1:0]  m_tdata;
  logic                 m_tready = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;
  logic signed [S-1:0] out_q[$];

  always #5 clk = ~clk;

  cic_decimator dut (
    .clk        (clk),
    .reset      (reset),
    .decim_log2 (decim_log2),
    .s_tvalid   (s_tvalid),
    .s_tdata    (s_tdata),
    .s_tready   (s_tready),
    .m_tvalid   (m_tvalid),
    .m_tdata    (m_tdata),
    .m_tready   (m_tready)
  );

  // Record each output handshake that the coming rising edge will complete.
  always @(negedge clk)
    if (!reset && m_tvalid && m_tready) out_q.push_back(m_tdata);

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] outq(input int i);
    if (i < out_q.size()) return 32'(out_q[i]);
    return 'x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    out_q.delete();
  endtask

  task automatic send(input logic signed [S-1:0] v);
    int guard = 0;
    s_tvalid = 1'b1;
    s_tdata  = v;
    @(negedge clk);
    while (!s_tready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("send_timeout", s_tready, 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int idx;
    int cyc;
    logic acc;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_s_tready", s_tready, 1);

    // DC 1000, R=4: one output per 4 accepts, valid the cycle after the 4th
    decim_log2 = 3'd2;
    for (int i = 1; i <= 24; i++) begin
      send(16'sd1000);
      chk("dc_latency", m_tvalid, (i % 4 == 0));
    end
    idle(2);
    chk("dc_count", out_q.size(), 6);
    chk("dc_out0", outq(0), DC0);
    chk("dc_out1", outq(1), DC1);
    for (int i = 2; i < 6; i++) chk("dc_settled", outq(i), 1000);

    // Impulse 640, R=4; a ratio change inside frame 1 must not take effect
    do_reset();
    decim_log2 = 3'd2;
    send(16'sd640);
    decim_log2 = 3'd5;
    repeat (3) send(16'sd0);
    decim_log2 = 3'd2;
    repeat (8) send(16'sd0);
    idle(2);
    chk("imp_count", out_q.size(), 3);
    chk("imp_out0", outq(0), 100);
    chk("imp_out1", outq(1), 60);
    chk("imp_out2", outq(2), 0);

    // Impulse 40, R=4: exposes truncation versus rounding
    do_reset();
    send(16'sd40);
    repeat (11) send(16'sd0);
    idle(2);
    chk("rnd_count", out_q.size(), 3);
    chk("rnd_out0", outq(0), 6);
    chk("rnd_out1", outq(1), IMP40_1);
    chk("rnd_out2", outq(2), 0);

    // Backpressure, R=2, ramp x[n] = 8(n+1): expected 5, 20, 36, 52, 68
    do_reset();
    decim_log2 = 3'd1;
    m_tready = 1'b0;
    idx = 0;
    s_tvalid = 1'b1;
    s_tdata = 16'sd8;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc = s_tready;
      if (c >= 2) begin
        chk("bp_tready_low", s_tready, 0);
        chk("bp_hold_data", m_tdata, 5);
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        s_tdata = S'(8 * (idx + 1));
      end
    end
    chk("bp_accepts", idx, 2);
    chk("bp_valid_held", m_tvalid, 1);
    m_tready = 1'b1;
    cyc = 0;
    while (idx < 10 && cyc < 60) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        s_tdata = S'(8 * (idx + 1));
      end
      cyc++;
    end
    chk("bp_resume_accepts", idx, 10);
    idle(3);
    chk("bp_count", out_q.size(), 5);
    chk("bp_out0", outq(0), 5);
    chk("bp_out1", outq(1), 20);
    chk("bp_out2", outq(2), 36);
    chk("bp_out3", outq(3), 52);
    chk("bp_out4", outq(4), 68);

    // Full scale, decim_log2=7 clamps to R=64; integrators wrap
    do_reset();
    decim_log2 = 3'd7;
    repeat (256) send(-16'sd32768);
    idle(2);
    chk("fs_count", out_q.size(), 4);
    chk("fs_out2", outq(2), -32768);
    chk("fs_out3", outq(3), -32768);

    // R=1: pass-through with one cycle of latency
    do_reset();
    decim_log2 = 3'd0;
    send(16'sd5);
    chk("r1_valid0", m_tvalid, 1);
    chk("r1_data0", m_tdata, 5);
    send(-16'sd7);
    chk("r1_valid1", m_tvalid, 1);
    chk("r1_data1", m_tdata, -7);
    send(16'sd32767);
    chk("r1_valid2", m_tvalid, 1);
    chk("r1_data2", m_tdata, 32767);
    idle(1);

    // Reset discards a held output
    m_tready = 1'b0;
    send(16'sd11);
    chk("hold_valid", m_tvalid, 1);
    chk("hold_data", m_tdata, 11);
    do_reset();
    chk("hold_rst_valid", m_tvalid, 0);
    chk("hold_rst_data", m_tdata, 0);
    chk("hold_rst_tready", s_tready, 1);
    m_tready = 1'b1;

    // Reset mid-frame, then DC 1000 must match a fresh start
    decim_log2 = 3'd2;
    send(16'sd1000);
    send(16'sd1000);
    do_reset();
    repeat (16) send(16'sd1000);
    idle(2);
    chk("mid_count", out_q.size(), 4);
    chk("mid_out0", outq(0), DC0);
    chk("mid_out1", outq(1), DC1);
    chk("mid_out2", outq(2), 1000);
    chk("mid_out3", outq(3), 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
